// File: rtl/mux8_rr_sched_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin mux scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux8_rr_sched_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot vector with only bit idx set.
    function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] one;
        one = {{(N_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Round-robin pick: first set request at or after ptr, wrapping mod 8.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is set.
// Ports: req[7:0] request vector, ptr[2:0] highest-priority index,
//        found any request set, idx[2:0] winning requester index.
module rr_pick8
    import mux8_rr_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [SEL_W-1:0]   off;

    always_comb begin
        // Doubling the vector turns the wrap-around rotate into a plain slice:
        // req_rot[0] is req[ptr], req_rot[1] is req[ptr+1], and so on.
        req_dbl = {req, req};
        req_rot = req_dbl[ptr +: N_REQ];

        // Lowest set bit of the rotated vector is the nearest requester after ptr.
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = SEL_W'(i);
            end
        end

        found = |req;
        // SEL_W-bit add wraps mod 8 for free.
        idx   = ptr + off;
    end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler owning the select of a shared 8:1 mux; one-hot grant per requester.
// Latency: grant 1 cycle after request in IDLE; one idle turnaround cycle after each release.
// Backpressure: a grant ends after HOLD cycles or when the holder drops req; en=0 blocks new grants only.
// Ports: clk, rst_n (async active-low), en scheduler enable, req[7:0] requests,
//        gnt[7:0] one-hot grant, sel[2:0] mux select (index of granted requester), busy grant active.
module mux8_rr_sched
    import mux8_rr_sched_pkg::*;
#(
    parameter int HOLD  = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             busy_nxt;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            sel   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        busy_nxt  = busy;

        case (state)
            IDLE: begin
                if (en && pick_found) begin
                    state_nxt = GRANT;
                    gnt_nxt   = onehot8(pick_idx);
                    sel_nxt   = pick_idx;
                    busy_nxt  = 1'b1;
                    // cnt counts the remaining extra cycles; the grant edge itself is the first.
                    cnt_nxt   = CNT_W'(HOLD - 1);
                end
            end
            GRANT: begin
                // Only the holder's request matters here; other req bits wait for IDLE.
                if (!req[sel] || cnt == '0) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    // The next scan starts just after the released holder (7 wraps to 0).
                    ptr_nxt   = sel + SEL_W'(1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed bench for mux8_rr_sched: stimulus pushes expected outputs, a monitor pops and compares.
// Latency: each expectation describes the outputs just after the next rising edge.
// Backpressure: n/a.
module tb_mux8_rr_sched;
    import mux8_rr_sched_pkg::*;

    typedef struct {
        bit         d;   // 0 = HOLD=8 instance, 1 = HOLD=2 instance
        logic [7:0] g;
        logic [2:0] s;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en8, en2;
    logic [7:0] req8, req2;
    logic [7:0] gnt8, gnt2;
    logic [2:0] sel8, sel2;
    logic       busy8, busy2;

    exp_t sb[$];
    int   total;
    int   bad;

    mux8_rr_sched #(.HOLD(8), .CNT_W(4)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en8),
        .req   (req8),
        .gnt   (gnt8),
        .sel   (sel8),
        .busy  (busy8)
    );

    mux8_rr_sched #(.HOLD(2), .CNT_W(4)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en2),
        .req   (req2),
        .gnt   (gnt2),
        .sel   (sel2),
        .busy  (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [7:0] g, input logic [2:0] s, input logic b,
                         input logic [7:0] eg, input logic [2:0] es);
        logic eb;
        eb = (eg != 8'h00);
        total++;
        if (g !== eg || s !== es || b !== eb) begin
            bad++;
            $display("FAIL %s @%0t: got gnt=%h sel=%0d busy=%b, want gnt=%h sel=%0d busy=%b",
                     name, $time, g, s, b, eg, es, eb);
        end
    endtask

    // Monitor: outputs are registered, so sample 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.d == 1'b0) check("dut8", gnt8, sel8, busy8, e.g, e.s);
                else             check("dut2", gnt2, sel2, busy2, e.g, e.s);
            end
        end
    end

    // Drive inputs on the falling edge; expectation is for the following rising edge.
    task automatic step(input bit d, input logic e, input logic [7:0] r,
                        input logic [7:0] eg, input logic [2:0] es);
        exp_t x;
        @(negedge clk);
        if (d == 1'b0) begin
            en8  = e;
            req8 = r;
        end else begin
            en2  = e;
            req2 = r;
        end
        x.d = d;
        x.g = eg;
        x.s = es;
        sb.push_back(x);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en8 = 1'b0; req8 = 8'h00;
        en2 = 1'b0; req2 = 8'h00;
        #1;
        check("reset_dut8", gnt8, sel8, busy8, 8'h00, 3'd0);
        check("reset_dut2", gnt2, sel2, busy2, 8'h00, 3'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single requester 3, full hold of 8 cycles, one gap, re-grant (ptr 0 -> 4).
        step(0, 1, 8'h08, 8'h08, 3'd3);
        for (int i = 0; i < 7; i++) step(0, 1, 8'h08, 8'h08, 3'd3);
        step(0, 1, 8'h08, 8'h00, 3'd3);
        step(0, 1, 8'h08, 8'h08, 3'd3);
        for (int i = 0; i < 7; i++) step(0, 1, 8'h08, 8'h08, 3'd3);
        step(0, 1, 8'h00, 8'h00, 3'd3);

        // Early release of requester 6 on its 3rd cycle (ptr -> 7), then 7 beats 0.
        step(0, 1, 8'h40, 8'h40, 3'd6);
        step(0, 1, 8'h40, 8'h40, 3'd6);
        step(0, 1, 8'h40, 8'h40, 3'd6);
        step(0, 1, 8'h00, 8'h00, 3'd6);
        step(0, 1, 8'h81, 8'h80, 3'd7);
        step(0, 1, 8'h00, 8'h00, 3'd7);   // ptr wraps to 0

        // Enable gating.
        step(0, 0, 8'h10, 8'h00, 3'd7);
        step(0, 0, 8'h10, 8'h00, 3'd7);
        step(0, 1, 8'h04, 8'h04, 3'd2);
        step(0, 0, 8'h04, 8'h04, 3'd2);   // en low does not abort
        step(0, 0, 8'h04, 8'h04, 3'd2);
        step(0, 0, 8'h00, 8'h00, 3'd2);   // ptr -> 3
        step(0, 0, 8'h10, 8'h00, 3'd2);
        step(0, 1, 8'h10, 8'h10, 3'd4);
        step(0, 1, 8'h00, 8'h00, 3'd4);   // ptr -> 5

        // Move ptr to 3, then bits 0 and 3 compete.
        step(0, 1, 8'h04, 8'h04, 3'd2);   // scan 5,6,7,0,1,2
        step(0, 1, 8'h00, 8'h00, 3'd2);   // ptr -> 3
        step(0, 1, 8'h09, 8'h08, 3'd3);
        step(0, 1, 8'h01, 8'h00, 3'd3);   // req[3] dropped, ptr -> 4
        step(0, 1, 8'h09, 8'h01, 3'd0);   // 0 wins via wrap
        step(0, 1, 8'h00, 8'h00, 3'd0);   // ptr -> 1

        // Reset asserted mid-grant to requester 5.
        step(0, 1, 8'h20, 8'h20, 3'd5);
        step(0, 1, 8'h20, 8'h20, 3'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset", gnt8, sel8, busy8, 8'h00, 3'd0);
        step(0, 1, 8'h00, 8'h00, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 8'h03, 8'h01, 3'd0);   // ptr back at 0, so 0 beats 1
        step(0, 1, 8'h00, 8'h00, 3'd0);
        @(negedge clk);
        en8 = 1'b0;

        // Round robin with HOLD=2, all requesting: 0..7 then 0 again.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] oh;
            oh = 8'h01 << i;
            step(1, 1, 8'hFF, oh, 3'(i));
            step(1, 1, 8'hFF, oh, 3'(i));
            step(1, 1, 8'hFF, 8'h00, 3'(i));
        end
        step(1, 1, 8'hFF, 8'h01, 3'd0);
        step(1, 1, 8'hFF, 8'h01, 3'd0);
        step(1, 1, 8'h00, 8'h00, 3'd0);

        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
